// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   md_op_e    - op select encodings carried on the op port
//   md_state_e - sequencer states
//   MD_WIDTH   - operand width, MD_ITERS - iteration count
//   md_abs     - two's-complement magnitude helper
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_ITER,
        MD_FIX,
        MD_DONE
    } md_state_e;

    // Magnitude of a signed value; 0x80000000 maps onto itself, which is
    // exactly the unsigned magnitude 2^31.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/response bundle for md_unit.
//   master (pipeline side): drives start/op/a/b and MTHI/MTLO strobes,
//                           observes busy/done/div_zero/hi/lo
//   slave  (md_unit side):  the reverse
import md_pkg::*;

interface md_unit_if;
    logic                start;
    logic [1:0]          op;
    logic [MD_WIDTH-1:0] a;
    logic [MD_WIDTH-1:0] b;
    logic                wr_hi;
    logic                wr_lo;
    logic [MD_WIDTH-1:0] wr_data;
    logic                busy;
    logic                done;
    logic                div_zero;
    logic [MD_WIDTH-1:0] hi;
    logic [MD_WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/md_step.sv
// md_step: one combinational multiply or divide iteration.
//   is_div   in  0 = shift-add multiply step, 1 = restoring divide step
//   acc      in  2*WIDTH accumulator ({P,Q} or {R,Q})
//   opnd     in  WIDTH   magnitude of the multiplier / divisor
//   acc_next out 2*WIDTH accumulator after the step
import md_pkg::*;

module md_step #(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] r_diff;

    always_comb begin
        // Multiply: conditional add into P with carry, then shift {carry,P,Q} right.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

        // Divide: R shifted left takes the top bit of Q, giving a 33-bit trial value.
        // When the trial fits, the true difference is below the divisor, so a
        // WIDTH-bit subtract is enough to form the new remainder.
        r_shift = acc[2*WIDTH-1:WIDTH-1];
        fits    = (r_shift >= {1'b0, opnd});
        r_diff  = r_shift[WIDTH-1:0] - opnd;

        if (is_div) begin
            acc_next = {(fits ? r_diff : r_shift[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of md_unit_if:
//          start/op/a/b   operation request (sampled in IDLE or DONE)
//          wr_hi/wr_lo/wr_data  MTHI/MTLO writes (IDLE or DONE, start wins)
//          busy/done/div_zero/hi/lo  status and architectural HI/LO
import md_pkg::*;

module md_unit #(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = MD_ITERS
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(ITERS) + 1;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               is_div;
    logic               is_signed;
    logic [2*WIDTH-1:0] step_acc;

    assign is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
    assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            MD_IDLE, MD_DONE: begin
                if (bus.start) begin
                    // Raw operands are parked in acc/opnd; PREP turns them into magnitudes.
                    state_d    = MD_PREP;
                    op_d       = md_op_e'(bus.op);
                    acc_d      = {{WIDTH{1'b0}}, bus.a};
                    opnd_d     = bus.b;
                    div_zero_d = 1'b0;
                end else begin
                    state_d = MD_IDLE;
                    if (bus.wr_hi) hi_d = bus.wr_data;
                    if (bus.wr_lo) lo_d = bus.wr_data;
                end
            end

            MD_PREP: begin
                cnt_d = '0;
                if (is_div && (opnd_q == '0)) begin
                    hi_d       = acc_q[WIDTH-1:0];
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                    state_d    = MD_DONE;
                end else begin
                    if (is_signed) begin
                        acc_d     = {{WIDTH{1'b0}}, md_abs(acc_q[WIDTH-1:0])};
                        opnd_d    = md_abs(opnd_q);
                        neg_res_d = acc_q[WIDTH-1] ^ opnd_q[WIDTH-1];
                        neg_rem_d = is_div & acc_q[WIDTH-1];
                    end else begin
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
                    state_d = MD_ITER;
                end
            end

            MD_ITER: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) state_d = MD_FIX;
            end

            MD_FIX: begin
                if (is_div) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                state_d = MD_DONE;
            end

            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            op_q       <= MD_MULTU;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q == MD_PREP) || (state_q == MD_ITER) || (state_q == MD_FIX);
    assign bus.done     = (state_q == MD_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. A cycle-level model computes
// results with native 64-bit arithmetic and tracks when they become visible;
// a compare process checks every output every cycle, and directed sequences
// pin literal expectations.
import md_pkg::*;

module tb_md_unit;

    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // t = current cycle index of an accepted operation (1..tdone), 0 when idle.
    int          t     = 0;
    int          tdone = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic        m_dz  = 1'b0;
    logic [31:0] r_hi, r_lo;
    logic        r_dz;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    longint      sa, sb;
    logic [63:0] p, q64, rm64;

    always @(posedge clk) begin
        if (reset) begin
            t = 0; tdone = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
        end else if (t >= 1 && t < tdone) begin
            t++;
            if (t == tdone) begin
                m_hi = r_hi; m_lo = r_lo; m_dz = r_dz;
            end
        end else if (bus.start) begin
            sa = longint'($signed(bus.a));
            sb = longint'($signed(bus.b));
            r_dz  = 1'b0;
            tdone = 35;
            case (bus.op)
                2'b00: begin
                    p = {32'b0, bus.a} * {32'b0, bus.b};
                    r_hi = p[63:32]; r_lo = p[31:0];
                end
                2'b01: begin
                    p = sa * sb;
                    r_hi = p[63:32]; r_lo = p[31:0];
                end
                default: begin
                    if (bus.b == 32'd0) begin
                        r_hi = bus.a; r_lo = 32'hFFFF_FFFF; r_dz = 1'b1; tdone = 2;
                    end else if (bus.op == 2'b10) begin
                        r_lo = bus.a / bus.b; r_hi = bus.a % bus.b;
                    end else begin
                        q64 = sa / sb; rm64 = sa % sb;
                        r_lo = q64[31:0]; r_hi = rm64[31:0];
                    end
                end
            endcase
            t = 1; m_dz = 1'b0;
        end else begin
            if (bus.wr_hi) m_hi = bus.wr_data;
            if (bus.wr_lo) m_lo = bus.wr_data;
            t = 0; tdone = 0;
        end
        exp_busy = (t >= 1) && (t < tdone);
        exp_done = (t != 0) && (t == tdone);
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        check("busy",     {63'b0, bus.busy},     {63'b0, exp_busy});
        check("done",     {63'b0, bus.done},     {63'b0, exp_done});
        check("div_zero", {63'b0, bus.div_zero}, {63'b0, m_dz});
        check("hi",       {32'b0, bus.hi},       {32'b0, m_hi});
        check("lo",       {32'b0, bus.lo},       {32'b0, m_lo});
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pin(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] lit);
        check({name, "_dut"},   {32'b0, dut_v}, {32'b0, lit});
        check({name, "_model"}, {32'b0, mdl_v}, {32'b0, lit});
    endtask

    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_dz",   {63'b0, bus.div_zero}, 64'd0);
        pin("rst_hi", bus.hi, m_hi, 32'h0);
        pin("rst_lo", bus.lo, m_lo, 32'h0);

        // MULTU max*max, with timing of busy/done
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_c1", {63'b0, bus.busy}, 64'd1);
        repeat (33) @(negedge clk);
        check("multu_busy_c34", {63'b0, bus.busy}, 64'd1);
        check("multu_done_c34", {63'b0, bus.done}, 64'd0);
        @(negedge clk);
        check("multu_done_c35", {63'b0, bus.done}, 64'd1);
        check("multu_busy_c35", {63'b0, bus.busy}, 64'd0);
        pin("multu_hi", bus.hi, m_hi, 32'hFFFF_FFFE);
        pin("multu_lo", bus.lo, m_lo, 32'h0000_0001);
        @(negedge clk);

        // MULT -3*7, then back-to-back DIV -7/2 started in the DONE cycle
        start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        repeat (34) @(negedge clk);
        pin("mult_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        pin("mult_lo", bus.lo, m_lo, 32'hFFFF_FFEB);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        check("b2b_done_low", {63'b0, bus.done}, 64'd0);
        repeat (34) @(negedge clk);
        pin("div_lo", bus.lo, m_lo, 32'hFFFF_FFFD);
        pin("div_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        @(negedge clk);

        // DIVU by zero, then the next start clears div_zero
        start_op(2'b10, 32'd100, 32'd0);
        @(negedge clk);
        check("dz_done_c2", {63'b0, bus.done}, 64'd1);
        check("dz_flag",    {63'b0, bus.div_zero}, 64'd1);
        pin("dz_hi", bus.hi, m_hi, 32'd100);
        pin("dz_lo", bus.lo, m_lo, 32'hFFFF_FFFF);
        @(negedge clk);
        check("dz_held", {63'b0, bus.div_zero}, 64'd1);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("dz_cleared", {63'b0, bus.div_zero}, 64'd0);
        repeat (34) @(negedge clk);
        pin("ovf_lo", bus.lo, m_lo, 32'h8000_0000);
        pin("ovf_hi", bus.hi, m_hi, 32'h0);
        check("ovf_dz", {63'b0, bus.div_zero}, 64'd0);
        @(negedge clk);

        // start and wr_hi while busy are ignored; wr_lo in IDLE is taken
        start_op(2'b00, 32'd12345, 32'd6789);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd999; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        repeat (24) @(negedge clk);
        check("ign_done", {63'b0, bus.done}, 64'd1);
        pin("ign_hi", bus.hi, m_hi, 32'h0);
        pin("ign_lo", bus.lo, m_lo, 32'h04FE_D79D);
        @(negedge clk);
        bus.wr_lo = 1'b1; bus.wr_data = 32'hABCD;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        pin("mtlo", bus.lo, m_lo, 32'hABCD);

        // reset in cycle 20 of a MULT aborts it; a fresh MULT then completes
        start_op(2'b01, 32'hFFFF_FFFB, 32'd9);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_done", {63'b0, bus.done}, 64'd0);
        pin("abort_hi", bus.hi, m_hi, 32'h0);
        pin("abort_lo", bus.lo, m_lo, 32'h0);
        repeat (20) @(negedge clk);
        start_op(2'b01, 32'hFFFF_FFFB, 32'd9);
        repeat (34) @(negedge clk);
        pin("fresh_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        pin("fresh_lo", bus.lo, m_lo, 32'hFFFF_FFD3);

        // randomized traffic: starts at any time, MTHI/MTLO, corner operands, rare resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            bus.a       = ra;
            bus.b       = rb;
            bus.op      = 2'($urandom_range(0, 3));
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.wr_hi   = ($urandom_range(0, 7) == 0);
            bus.wr_lo   = ($urandom_range(0, 7) == 0);
            bus.wr_data = $urandom;
            reset       = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide controller for the MIPS execute stage. It sequences one 32-bit add/subtract-and-shift step per cycle to produce MULT/MULTU/DIV/DIVU results in the HI/LO register pair. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. It sits beside the main ALU, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `ITERS`, default 32: iteration count. Must equal `WIDTH`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Captured with `start`.
- `a`  in  32  multiplicand or dividend. Captured with `start`.
- `b`  in  32  multiplier or divisor. Captured with `start`.
- `wr_hi`  in  1  MTHI strobe.
- `wr_lo`  in  1  MTLO strobe.
- `wr_data`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  last division had a zero divisor. Held until the next accepted `start`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States and transitions:
  - IDLE → PREP on `start`.
  - PREP → ITER normally; PREP → DONE on a divide with `b == 0`.
  - ITER → FIX after `ITERS` steps.
  - FIX → DONE.
  - DONE → PREP on `start`, otherwise DONE → IDLE.
- PREP:
  - Signed ops (01, 11): latch `|a|` and `|b|`, plus the result sign and the remainder sign (the sign of `a`).
  - Unsigned ops: latch the operands unchanged.
  - Iteration counter is cleared.
- ITER, multiply: shift-add. A 64-bit accumulator `{P, Q}` starts as `{0, |a|}`. Each step: if `Q[0]` is set, add `|b|` to `P` with a 33-bit carry; then shift the whole accumulator right by 1.
- ITER, divide: restoring division. Shift `{R, Q}` left by 1; compute trial `R − |b|` in 33 bits; if it is non-negative, commit the difference and set `Q[0] = 1`.
- FIX, multiply: negate the 64-bit product if the result sign is negative; write `{hi, lo}`.
- FIX, divide:
  - `lo` = quotient, negated if the result sign is negative (truncation toward zero).
  - `hi` = remainder, negated if the dividend was negative.
- DIV 0x80000000 / 0xFFFFFFFF produces `lo = 0x80000000`, `hi = 0`. This is the natural wrap; there is no trap.
- Divide by zero: `hi = a`, `lo = 0xFFFFFFFF`, `div_zero = 1`. No iterations are run.
- `busy` is 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
- `start` while `busy` is ignored; nothing is captured.
- `wr_hi` / `wr_lo`:
  - Accepted only in IDLE or DONE; update on the next edge.
  - Ignored while `busy`.
  - Ignored if asserted in the same cycle as an accepted `start` (start wins).
- `hi` / `lo` are architectural registers: they change only in FIX, on the divide-by-zero path, on an accepted write, or on reset. Partial results never appear on them.

## Timing
- Reset values: state IDLE; `busy = 0`, `done = 0`, `div_zero = 0`, `hi = 0`, `lo = 0`; counter 0.
- Reset asserted mid-operation aborts on the next edge: all of the above values are restored and the in-flight result is discarded.
- Cycle numbering: `start` is high and accepted in cycle 0.
  - Cycle 1: PREP.
  - Cycles 2–33: ITER.
  - Cycle 34: FIX.
  - Cycle 35: DONE; `done = 1` and `hi` / `lo` are valid.
- Divide by zero: PREP in cycle 1, `done = 1` in cycle 2.
- `busy` rises in cycle 1 and falls in the DONE cycle.
- Back-to-back: `start` in the DONE cycle is accepted, and `done` stays low in the following cycle.
- `done` is never high for two consecutive cycles.

## Structure
- Package `md_pkg`:
  - Op encodings `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`.
  - State enum (IDLE, PREP, ITER, FIX, DONE).
  - Constant `MD_ITERS = 32`.
- One combinational sub-module, `md_step`: a single multiply or divide iteration, taking (mode, accumulator, operand) and returning the next accumulator. The FSM, counter, sign handling and HI/LO registers live in `md_unit`.

## Test plan
- MULTU `a = 0xFFFFFFFF`, `b = 0xFFFFFFFF` → cycle 35: `done = 1`, `hi = 0xFFFFFFFE`, `lo = 0x00000001`; `busy` high in cycles 1–34.
- MULT `a = -3`, `b = 7` → `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFEB`. DIV `a = -7`, `b = 2` → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`.
- DIVU `a = 100`, `b = 0` → cycle 2: `done = 1`, `div_zero = 1`, `hi = 100`, `lo = 0xFFFFFFFF`. The next accepted `start` clears `div_zero`.
- DIV `0x80000000 / 0xFFFFFFFF` → `lo = 0x80000000`, `hi = 0`, `div_zero = 0`.
- During an operation in flight, pulse `start` with new operands in cycle 5 and `wr_hi` with `0x1234` in cycle 10 → both ignored and the original result appears in cycle 35. Then `wr_lo` with `0xABCD` in IDLE → `lo = 0xABCD` on the next cycle.
- `reset` asserted in cycle 20 of a MULT → next cycle: IDLE, `busy = 0`, `hi = lo = 0`, and no `done` pulse. A fresh `start` afterwards completes with the correct result.
